ipsxe_floating_point_z_group1_prod_gen_v1_0: RTL and testbench

Iterative fabric multiplier that produces the z * group1 product in the packed "rne2_dlt17zeros" form consumed by the z * group1 RNE rounding APM stage. It multiplies a half-width z operand by a group1 operand RNE2 bits wide, K bits per cycle. It drops the 17 guaranteed-zero product MSBs, flags a violation if any of them is set, and presents the result with a valid/ready handshake. It sits on the invsqrt datapath between the z/group1 generation logic and the rounding APM.

---
 rtl/ipsxe_floating_point_z_group1_prod_gen_v1_0_pkg.sv | 24 ++
 rtl/ipsxe_floating_point_z_group1_prod_gen_v1_0_partial_mac.sv | 26 ++
 rtl/ipsxe_floating_point_z_group1_prod_gen_v1_0.sv | 114 +++++++++++
 tb/tb_ipsxe_floating_point_z_group1_prod_gen_v1_0.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_z_group1_prod_gen_v1_0_pkg.sv
// Shared widths, constants and state encoding for the z * group1 product generator.
package ipsxe_floating_point_z_group1_prod_gen_v1_0_pkg;

    localparam int DLT_ZEROS = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_zw(input int man_width, input int rne, input int rne1);
        return ((man_width + 1) + rne + rne1) / 2;
    endfunction

    function automatic int calc_ow(input int zw, input int rne2);
        return zw + rne2 - DLT_ZEROS;
    endfunction

    function automatic int calc_n(input int rne2, input int k);
        return rne2 / k;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_z_group1_prod_gen_v1_0_partial_mac.sv
// Purpose: one ZW x K partial product, shifted to its digit position and added to the accumulator.
// Latency: combinational.
// Backpressure: none; the caller decides when acc_out is captured.
module ipsxe_floating_point_partial_mac_v1_0 #(
    parameter int ZW = 52,
    parameter int K  = 4,
    parameter int AW = 96,
    parameter int CW = 4
) (
    input  logic [AW-1:0] acc_in,
    input  logic [ZW-1:0] a,
    input  logic [K-1:0]  digit,
    input  logic [CW-1:0] cnt,
    output logic [AW-1:0] acc_out
);

    logic [ZW+K-1:0] pp;
    logic [AW-1:0]   pp_shifted;

    always_comb begin
        pp         = {{K{1'b0}}, a} * {{ZW{1'b0}}, digit};
        pp_shifted = AW'(pp) << (K * 32'(cnt));
        acc_out    = acc_in + pp_shifted;
    end

endmodule

// File: rtl/ipsxe_floating_point_z_group1_prod_gen_v1_0.sv
// Purpose: iterative z * group1 multiplier, K bits per cycle, top 17 product bits dropped and checked.
// Latency: o_valid rises N edges after the accept edge; issue period N+2.
// Backpressure: result held in DONE until i_ready; o_ready low outside IDLE.
module ipsxe_floating_point_z_group1_prod_gen_v1_0
    import ipsxe_floating_point_z_group1_prod_gen_v1_0_pkg::*;
#(
    parameter int MAN_WIDTH = 52,
    parameter int RNE       = 2,
    parameter int RNE1      = 49,
    parameter int RNE2      = 44,
    parameter int K         = 4,
    localparam int ZW       = calc_zw(MAN_WIDTH, RNE, RNE1),
    localparam int OW       = calc_ow(ZW, RNE2)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [ZW-1:0] i_z,
    input  logic [RNE2-1:0] i_group1,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_z_group1_rne2_dlt17zeros,
    output logic          o_dlt_err
);

    localparam int N  = calc_n(RNE2, K);
    localparam int AW = ZW + RNE2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (RNE2 % K != 0) begin : g_bad_k
        $error("RNE2 must be a multiple of K");
    end

    state_t          state_q, state_d;
    logic [ZW-1:0]   a_reg;
    logic [RNE2-1:0] b_reg;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_nxt;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   out_q;
    logic            err_q;

    ipsxe_floating_point_partial_mac_v1_0 #(
        .ZW (ZW),
        .K  (K),
        .AW (AW),
        .CW (CW)
    ) u_partial_mac (
        .acc_in  (acc),
        .a       (a_reg),
        .digit   (b_reg[K-1:0]),
        .cnt     (cnt),
        .acc_out (acc_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid)         state_d = RUN;
            RUN:     if (cnt == CNT_LAST) state_d = DONE;
            DONE:    if (i_ready)         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_reg <= i_z;
                        b_reg <= i_group1;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    b_reg <= b_reg >> K;
                    cnt   <= cnt + CW'(1);
                    // Final digit: publish the result the same edge DONE is entered.
                    if (cnt == CNT_LAST) begin
                        out_q <= acc_nxt[OW-1:0];
                        err_q <= |acc_nxt[AW-1:OW];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready                    = (state_q == IDLE);
    assign o_valid                    = (state_q == DONE);
    assign o_z_group1_rne2_dlt17zeros = out_q;
    assign o_dlt_err                  = err_q;

endmodule

// File: tb/tb_ipsxe_floating_point_z_group1_prod_gen_v1_0.sv
// Directed and back-to-back checks of the z * group1 iterative product generator.
module tb_ipsxe_floating_point_z_group1_prod_gen_v1_0;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [51:0] i_z;
    logic [43:0] i_group1;
    logic        o_valid;
    logic        i_ready;
    logic [78:0] o_out;
    logic        o_dlt_err;

    int n_vec;
    int n_bad;

    ipsxe_floating_point_z_group1_prod_gen_v1_0 dut (
        .i_clk                      (clk),
        .i_rst                      (rst),
        .i_valid                    (i_valid),
        .o_ready                    (o_ready),
        .i_z                        (i_z),
        .i_group1                   (i_group1),
        .o_valid                    (o_valid),
        .i_ready                    (i_ready),
        .o_z_group1_rne2_dlt17zeros (o_out),
        .o_dlt_err                  (o_dlt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepts one operand pair and returns the number of edges until o_valid.
    task automatic do_op(input logic [51:0] z, input logic [43:0] g, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!o_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        i_z      = z;
        i_group1 = g;
        i_valid  = 1'b1;
        @(negedge clk);
        i_valid  = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [127:0] full_prod(input logic [51:0] z, input logic [43:0] g);
        logic [127:0] zz, gg;
        zz = {76'b0, z};
        gg = {84'b0, g};
        return zz * gg;
    endfunction

    task automatic op_check(input string tag, input logic [51:0] z, input logic [43:0] g);
        int lat;
        logic [127:0] p;
        p = full_prod(z, g);
        do_op(z, g, lat);
        check({tag, "_lat"}, 128'(lat), 128'd11);
        check({tag, "_vld"}, 128'(o_valid), 128'd1);
        check({tag, "_out"}, 128'(o_out), {49'b0, p[78:0]});
        check({tag, "_err"}, 128'(o_dlt_err), 128'(|p[95:79]));
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("release_rdy", 128'(o_ready), 128'd1);
        check("release_vld", 128'(o_valid), 128'd0);
    endtask

    initial begin
        logic [78:0]  held;
        logic [127:0] big;
        logic [78:0]  q_out[$];
        logic         q_err[$];
        logic [51:0]  rz;
        logic [43:0]  rg;
        logic [127:0] rp;
        int           lat;
        int           nsent, nres, cyc, prev_t;

        n_vec    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_z      = '0;
        i_group1 = '0;
        #12;
        check("rst_rdy", 128'(o_ready), 128'd1);
        check("rst_vld", 128'(o_valid), 128'd0);
        check("rst_out", 128'(o_out), 128'd0);
        check("rst_err", 128'(o_dlt_err), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        op_check("unit", 52'd1, 44'd1);
        check("unit_out_abs", 128'(o_out), 128'd1);
        release_result();

        op_check("topbit", 52'd1 << 40, 44'd1 << 38);
        big = 128'd1 << 78;
        check("topbit_abs", 128'(o_out), big);
        release_result();

        op_check("ovf", {52{1'b1}}, {44{1'b1}});
        big = (128'd1 << 96) - (128'd1 << 52) - (128'd1 << 44) + 128'd1;
        check("ovf_abs", 128'(o_out), {49'b0, big[78:0]});
        check("ovf_err_abs", 128'(o_dlt_err), 128'd1);
        release_result();

        op_check("zero", 52'd0, 44'h123456789);
        release_result();

        // Back-pressure: hold in DONE and poke i_valid with other operands.
        op_check("bp", 52'd7, 44'd9);
        held = o_out;
        for (int i = 0; i < 20; i++) begin
            i_valid  = i[0];
            i_z      = 52'(i + 100);
            i_group1 = 44'(i + 3);
            @(negedge clk);
            check("bp_vld", 128'(o_valid), 128'd1);
            check("bp_rdy", 128'(o_ready), 128'd0);
            check("bp_out", 128'(o_out), 128'd63);
        end
        i_valid = 1'b0;
        release_result();
        check("bp_out_kept", 128'(o_out), 128'(held));

        // Async reset in the middle of RUN.
        i_z      = 52'd11;
        i_group1 = 44'd13;
        i_valid  = 1'b1;
        @(negedge clk);
        i_valid  = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_run_rdy", 128'(o_ready), 128'd0);
        rst = 1'b1;
        #1;
        check("arst_vld", 128'(o_valid), 128'd0);
        check("arst_rdy", 128'(o_ready), 128'd1);
        check("arst_out", 128'(o_out), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(52'd3, 44'd5, lat);
        check("post_rst_lat", 128'(lat), 128'd11);
        check("post_rst_out", 128'(o_out), 128'd15);
        check("post_rst_err", 128'(o_dlt_err), 128'd0);
        release_result();

        // Back-to-back random traffic.
        i_ready = 1'b1;
        nsent   = 0;
        nres    = 0;
        cyc     = 0;
        prev_t  = -1;
        while (nres < 1000 && cyc < 14000) begin
            @(negedge clk);
            cyc++;
            if (o_valid) begin
                if (q_out.size() == 0) begin
                    check("b2b_unexpected", 128'd1, 128'd0);
                end else begin
                    check("b2b_out", 128'(o_out), 128'(q_out.pop_front()));
                    check("b2b_err", 128'(o_dlt_err), 128'(q_err.pop_front()));
                end
                if (prev_t >= 0) check("b2b_period", 128'(cyc - prev_t), 128'd13);
                prev_t = cyc;
                nres++;
            end
            if (o_ready && nsent < 1000) begin
                rz = 52'({$urandom, $urandom});
                rg = 44'({$urandom, $urandom});
                if (nsent == 1) begin
                    rz = {52{1'b1}};
                    rg = {44{1'b1}};
                end
                rp = full_prod(rz, rg);
                q_out.push_back(rp[78:0]);
                q_err.push_back(|rp[95:79]);
                i_z      = rz;
                i_group1 = rg;
                i_valid  = 1'b1;
                nsent++;
            end else if (nsent >= 1000) begin
                i_valid = 1'b0;
            end
        end
        check("b2b_count", 128'(nres), 128'd1000);
        i_valid = 1'b0;
        i_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
